aes_dec_top: RTL and testbench
==============================

AES_DEC_TOP -- requirements
Module: aes_dec_top

Interface
REQ-001 SHALL have no parameters; AES-128 only (Nk=4, Nr=10).
REQ-002 SHALL have one clock and one reset: reset is synchronous and active-high.
REQ-003 CLK  input  1  rising-edge clock for all state.
REQ-004 RST  input  1  synchronous active-high reset.
REQ-005 start_in  input  1  request; samples ciphertext and key when accepted.
REQ-006 ciphertext0_in..ciphertext3_in  input  32 each  ciphertext block; word0 = bits [127:96].
REQ-007 key0_in..key3_in  input  32 each  cipher key; word0 = bits [127:96].
REQ-008 plaintext0_out..plaintext3_out  output  32 each  registered plaintext; word0 = bits [127:96].
REQ-009 valid_out  output  1  one-cycle pulse; plaintext outputs valid.
REQ-010 busy_out  output  1  high while a block is in progress.

Function
REQ-011 SHALL implement FIPS-197 InvCipher, iterative, one round per clock.
REQ-012 SHALL use states IDLE, KEYEXP and ROUND.
REQ-013 IDLE: start_in=1 at edge N -> latch ciphertext and key, busy_out<=1, go to KEYEXP with round counter=1.
REQ-014 KEYEXP: each edge SHALL advance the forward key schedule one round key (rk1..rk10).
REQ-015 At the edge producing rk10, SHALL load the state register with ciphertext XOR rk10 and go to ROUND.
REQ-016 ROUND: each edge SHALL apply InvShiftRows, InvSubBytes and AddRoundKey(rk_r), then InvMixColumns, for r=9..1.
REQ-017 Final round r=0 SHALL omit InvMixColumns.
REQ-018 During ROUND, rk_{r} SHALL be derived on the fly from rk_{r+1} by the inverse key schedule; there is no 11-entry key store.
REQ-019 Latency without cache SHALL be start edge N -> valid_out high in the cycle after edge N+20.
REQ-020 At that edge, plaintext outputs SHALL update, valid_out<=1 for exactly one cycle, busy_out<=0, and state returns to IDLE.
REQ-021 Plaintext outputs SHALL hold their value until the next completion or reset.
REQ-022 start_in while busy_out=1 SHALL be ignored; there is no queueing and latched inputs are unaffected.
REQ-023 start_in in the cycle valid_out=1 (state IDLE) SHALL be accepted normally.
REQ-024 Input changes after acceptance SHALL NOT affect the result.
REQ-025 InvSBox and SBox SHALL be combinational lookup; GF(2^8) multiply by 09/0B/0D/0E uses xtime with polynomial 0x11B.

Reset
REQ-026 RST=1 at any edge SHALL force IDLE, round counter=0, busy_out=0, valid_out=0 and all plaintext outputs=0.
REQ-027 RST=1 mid-operation SHALL abort with no valid_out pulse.
REQ-028 start_in SHALL be ignored while RST=1.
REQ-029 The first start is accepted at the first edge with RST=0.

Configuration
REQ-030 Macro AES_DEC_KEY_CACHE_EN defined: SHALL store the last rk10 plus its cipher key and a cache-valid flag.
REQ-031 With AES_DEC_KEY_CACHE_EN, on accept with cache-valid and key equal to the cached key, SHALL skip KEYEXP and load the state with ciphertext XOR cached rk10 at the start edge; latency is 10 cycles (valid_out after edge N+10).
REQ-032 With AES_DEC_KEY_CACHE_EN, RST SHALL clear cache-valid.
REQ-033 With AES_DEC_KEY_CACHE_EN, cache-valid SHALL be set and the cache updated when a KEYEXP completes.
REQ-034 Macro undefined: no cache logic; every block takes 20 cycles.

Verification
REQ-035 Key 000102030405060708090a0b0c0d0e0f, ct 69c4e0d86a7b0430d8cdb78070b4c55a -> pt 00112233445566778899aabbccddeeff; valid_out exactly 20 cycles after start edge; busy_out high throughout.
REQ-036 Key 2b7e151628aed2a6abf7158809cf4f3c, ct 3925841d02dc09fbdc118597196a0b32 -> pt 3243f6a8885a308d313198a2e0370734.
REQ-037 Key 5468617473206D79204B756E67204675, ct 29C3505F571420F6402299B31A02D73A -> pt 54776F204F6E65204E696E652054776F.
REQ-038 Same key twice back-to-back, second start in the valid_out cycle -> both plaintexts correct; second latency 20 without the macro, 10 with AES_DEC_KEY_CACHE_EN.
REQ-039 start_in pulsed at cycle 5 of a block with different data -> ignored; first result correct; no extra valid_out.
REQ-040 RST asserted at cycle 12 of a block -> outputs 0, no valid_out, busy_out=0; a new REQ-035 block afterwards passes (cache miss with the macro defined).

Source files
------------

// File: rtl/aes_dec_top.sv
// Iterative AES-128 decryptor: forward key expansion, then one InvCipher round per clock.
// Define AES_DEC_KEY_CACHE_EN to keep the last rk10 and skip key expansion on a repeated key.
module aes_dec_top (
  input  logic        CLK,
  input  logic        RST,
  input  logic        start_in,
  input  logic [31:0] ciphertext0_in,
  input  logic [31:0] ciphertext1_in,
  input  logic [31:0] ciphertext2_in,
  input  logic [31:0] ciphertext3_in,
  input  logic [31:0] key0_in,
  input  logic [31:0] key1_in,
  input  logic [31:0] key2_in,
  input  logic [31:0] key3_in,
  output logic [31:0] plaintext0_out,
  output logic [31:0] plaintext1_out,
  output logic [31:0] plaintext2_out,
  output logic [31:0] plaintext3_out,
  output logic        valid_out,
  output logic        busy_out
);

  localparam logic [2047:0] SboxTbl = {
    256'h637c777bf26b6fc53001672bfed7ab76ca82c97dfa5947f0add4a2af9ca472c0,
    256'hb7fd9326363ff7cc34a5e5f171d8311504c723c31896059a071280e2eb27b275,
    256'h09832c1a1b6e5aa0523bd6b329e32f8453d100ed20fcb15b6acbbe394a4c58cf,
    256'hd0efaafb434d338545f9027f503c9fa851a3408f929d38f5bcb6da2110fff3d2,
    256'hcd0c13ec5f974417c4a77e3d645d197360814fdc222a908846eeb814de5e0bdb,
    256'he0323a0a4906245cc2d3ac629195e479e7c8376d8dd54ea96c56f4ea657aae08,
    256'hba78252e1ca6b4c6e8dd741f4bbd8b8a703eb5664803f60e613557b986c11d9e,
    256'he1f8981169d98e949b1e87e9ce5528df8ca1890dbfe6426841992d0fb054bb16
  };

  localparam logic [2047:0] InvSboxTbl = {
    256'h52096ad53036a538bf40a39e81f3d7fb7ce339829b2fff87348e4344c4dee9cb,
    256'h547b9432a6c2233dee4c950b42fac34e082ea16628d924b2765ba2496d8bd125,
    256'h72f8f66486689816d4a45ccc5d65b6926c704850fdedb9da5e154657a78d9d84,
    256'h90d8ab008cbcd30af7e45805b8b34506d02c1e8fca3f0f02c1afbd0301138a6b,
    256'h3a9111414f67dcea97f2cfcef0b4e67396ac7422e7ad3585e2f937e81c75df6e,
    256'h47f11a711d29c5896fb7620eaa18be1bfc563e4bc6d279209adbc0fe78cd5af4,
    256'h1fdda8338807c731b11210592780ec5f60517fa919b54a0d2de57a9f93c99cef,
    256'ha0e03b4dae2af5b0c8ebbb3c83539961172b047eba77d626e169146355210c7d
  };

  function automatic logic [7:0] sbox(input logic [7:0] b);
    return SboxTbl[2047 - 8 * int'(b) -: 8];
  endfunction

  function automatic logic [7:0] inv_sbox(input logic [7:0] b);
    return InvSboxTbl[2047 - 8 * int'(b) -: 8];
  endfunction

  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] mul9(input logic [7:0] b);
    return xtime(xtime(xtime(b))) ^ b;
  endfunction

  function automatic logic [7:0] mulb(input logic [7:0] b);
    return xtime(xtime(xtime(b))) ^ xtime(b) ^ b;
  endfunction

  function automatic logic [7:0] muld(input logic [7:0] b);
    return xtime(xtime(xtime(b))) ^ xtime(xtime(b)) ^ b;
  endfunction

  function automatic logic [7:0] mule(input logic [7:0] b);
    return xtime(xtime(xtime(b))) ^ xtime(xtime(b)) ^ xtime(b);
  endfunction

  function automatic logic [7:0] rcon(input logic [3:0] k);
    logic [7:0] r;
    case (k)
      4'd1:    r = 8'h01;
      4'd2:    r = 8'h02;
      4'd3:    r = 8'h04;
      4'd4:    r = 8'h08;
      4'd5:    r = 8'h10;
      4'd6:    r = 8'h20;
      4'd7:    r = 8'h40;
      4'd8:    r = 8'h80;
      4'd9:    r = 8'h1b;
      4'd10:   r = 8'h36;
      default: r = 8'h00;
    endcase
    return r;
  endfunction

  // Byte k of a block sits at [127-8k -: 8]; column c holds bytes 4c..4c+3, row r is byte 4c+r.
  function automatic logic [127:0] inv_shift_sub(input logic [127:0] s);
    logic [127:0] o;
    o = '0;
    for (int c = 0; c < 4; c++) begin
      for (int r = 0; r < 4; r++) begin
        o[127 - 8 * (4 * c + r) -: 8] = inv_sbox(s[127 - 8 * (4 * ((c - r + 4) % 4) + r) -: 8]);
      end
    end
    return o;
  endfunction

  function automatic logic [31:0] inv_mix_col(input logic [31:0] c);
    logic [7:0] a0, a1, a2, a3;
    {a0, a1, a2, a3} = c;
    return {mule(a0) ^ mulb(a1) ^ muld(a2) ^ mul9(a3),
            mul9(a0) ^ mule(a1) ^ mulb(a2) ^ muld(a3),
            muld(a0) ^ mul9(a1) ^ mule(a2) ^ mulb(a3),
            mulb(a0) ^ muld(a1) ^ mul9(a2) ^ mule(a3)};
  endfunction

  function automatic logic [127:0] inv_mix(input logic [127:0] s);
    return {inv_mix_col(s[127:96]), inv_mix_col(s[95:64]),
            inv_mix_col(s[63:32]), inv_mix_col(s[31:0])};
  endfunction

  typedef enum logic [1:0] {StIdle, StKeyExp, StRound} state_e;

  state_e       state_q, state_d;
  logic [3:0]   rnd_q, rnd_d;
  logic [127:0] key_q, key_d;
  logic [127:0] data_q, data_d;
  logic [127:0] pt_q, pt_d;
  logic         valid_q, valid_d;
  logic         busy_q, busy_d;

  logic [127:0] ct_in, key_in;
  logic [31:0]  sw_in, sw_out;
  logic [3:0]   rc_idx;
  logic [127:0] fwd_rk, inv_rk, sub_out, round_out;

  assign ct_in  = {ciphertext0_in, ciphertext1_in, ciphertext2_in, ciphertext3_in};
  assign key_in = {key0_in, key1_in, key2_in, key3_in};

  // One SubWord/RotWord/Rcon path serves both directions: forward uses w3 of rk_i,
  // inverse recovers w3 of rk_r as w3^w2 of rk_{r+1}.
  assign sw_in  = (state_q == StRound) ? (key_q[31:0] ^ key_q[63:32]) : key_q[31:0];
  assign rc_idx = (state_q == StRound) ? (rnd_q + 4'd1) : rnd_q;
  assign sw_out = {sbox(sw_in[23:16]), sbox(sw_in[15:8]), sbox(sw_in[7:0]), sbox(sw_in[31:24])}
                  ^ {rcon(rc_idx), 24'h0};

  always_comb begin
    fwd_rk[127:96] = key_q[127:96] ^ sw_out;
    fwd_rk[95:64]  = key_q[95:64] ^ fwd_rk[127:96];
    fwd_rk[63:32]  = key_q[63:32] ^ fwd_rk[95:64];
    fwd_rk[31:0]   = key_q[31:0] ^ fwd_rk[63:32];
  end

  assign inv_rk = {key_q[127:96] ^ sw_out,
                   key_q[95:64] ^ key_q[127:96],
                   key_q[63:32] ^ key_q[95:64],
                   key_q[31:0] ^ key_q[63:32]};

  assign sub_out   = inv_shift_sub(data_q) ^ inv_rk;
  assign round_out = (rnd_q == 4'd0) ? sub_out : inv_mix(sub_out);

`ifdef AES_DEC_KEY_CACHE_EN
  logic         cache_vld_q, cache_vld_d;
  logic [127:0] cache_key_q, cache_key_d;
  logic [127:0] cache_rk_q, cache_rk_d;
  logic         cache_hit;

  assign cache_hit = cache_vld_q && (cache_key_q == key_in);
`endif

  always_comb begin
    state_d = state_q;
    rnd_d   = rnd_q;
    key_d   = key_q;
    data_d  = data_q;
    pt_d    = pt_q;
    valid_d = 1'b0;
    busy_d  = busy_q;
`ifdef AES_DEC_KEY_CACHE_EN
    cache_vld_d = cache_vld_q;
    cache_key_d = cache_key_q;
    cache_rk_d  = cache_rk_q;
`endif
    unique case (state_q)
      StIdle: begin
        if (start_in) begin
          busy_d = 1'b1;
`ifdef AES_DEC_KEY_CACHE_EN
          if (cache_hit) begin
            data_d  = ct_in ^ cache_rk_q;
            key_d   = cache_rk_q;
            rnd_d   = 4'd9;
            state_d = StRound;
          end else begin
            // Cache entry is rebuilt for this key once expansion finishes.
            cache_vld_d = 1'b0;
            cache_key_d = key_in;
            data_d      = ct_in;
            key_d       = key_in;
            rnd_d       = 4'd1;
            state_d     = StKeyExp;
          end
`else
          data_d  = ct_in;
          key_d   = key_in;
          rnd_d   = 4'd1;
          state_d = StKeyExp;
`endif
        end
      end
      StKeyExp: begin
        key_d = fwd_rk;
        rnd_d = rnd_q + 4'd1;
        if (rnd_q == 4'd10) begin
          data_d  = data_q ^ fwd_rk;
          rnd_d   = 4'd9;
          state_d = StRound;
`ifdef AES_DEC_KEY_CACHE_EN
          cache_vld_d = 1'b1;
          cache_rk_d  = fwd_rk;
`endif
        end
      end
      StRound: begin
        key_d  = inv_rk;
        data_d = round_out;
        rnd_d  = rnd_q - 4'd1;
        if (rnd_q == 4'd0) begin
          pt_d    = round_out;
          valid_d = 1'b1;
          busy_d  = 1'b0;
          rnd_d   = 4'd0;
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= StIdle;
      rnd_q   <= 4'd0;
      key_q   <= '0;
      data_q  <= '0;
      pt_q    <= '0;
      valid_q <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      rnd_q   <= rnd_d;
      key_q   <= key_d;
      data_q  <= data_d;
      pt_q    <= pt_d;
      valid_q <= valid_d;
      busy_q  <= busy_d;
    end
  end

`ifdef AES_DEC_KEY_CACHE_EN
  always_ff @(posedge CLK) begin
    if (RST) begin
      cache_vld_q <= 1'b0;
      cache_key_q <= '0;
      cache_rk_q  <= '0;
    end else begin
      cache_vld_q <= cache_vld_d;
      cache_key_q <= cache_key_d;
      cache_rk_q  <= cache_rk_d;
    end
  end
`endif

  assign plaintext0_out = pt_q[127:96];
  assign plaintext1_out = pt_q[95:64];
  assign plaintext2_out = pt_q[63:32];
  assign plaintext3_out = pt_q[31:0];
  assign valid_out      = valid_q;
  assign busy_out       = busy_q;

endmodule

// File: tb/tb_aes_dec_top.sv
// Bench for aes_dec_top: known-answer vectors plus random blocks against a FIPS-197 model
// whose S-boxes are derived from GF(2^8) inversion and the affine map.
module tb_aes_dec_top;

  logic         CLK = 1'b0;
  logic         RST;
  logic         start_in;
  logic [127:0] ct_drv, key_drv;
  logic [31:0]  pt0, pt1, pt2, pt3;
  logic         valid_out, busy_out;
  logic [127:0] pt_out;

  int n_checks = 0;
  int n_errors = 0;

  logic [7:0]   sbox_t[256];
  logic [7:0]   isbox_t[256];
  logic [127:0] last_pt;
  logic         cache_vld;
  logic [127:0] cache_key;

  always #5 CLK = ~CLK;

  assign pt_out = {pt0, pt1, pt2, pt3};

  aes_dec_top dut (
    .CLK            (CLK),
    .RST            (RST),
    .start_in       (start_in),
    .ciphertext0_in (ct_drv[127:96]),
    .ciphertext1_in (ct_drv[95:64]),
    .ciphertext2_in (ct_drv[63:32]),
    .ciphertext3_in (ct_drv[31:0]),
    .key0_in        (key_drv[127:96]),
    .key1_in        (key_drv[95:64]),
    .key2_in        (key_drv[63:32]),
    .key3_in        (key_drv[31:0]),
    .plaintext0_out (pt0),
    .plaintext1_out (pt1),
    .plaintext2_out (pt2),
    .plaintext3_out (pt3),
    .valid_out      (valid_out),
    .busy_out       (busy_out)
  );

  task automatic check_eq(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p, x;
    p = 8'h00;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
    end
    return p;
  endfunction

  function automatic logic [7:0] rotl8(input logic [7:0] x, input int k);
    return (x << k) | (x >> (8 - k));
  endfunction

  task automatic init_tables();
    logic [7:0] inv, s;
    for (int a = 0; a < 256; a++) begin
      inv = 8'h00;
      for (int b = 1; b < 256; b++) begin
        if (gmul(8'(a), 8'(b)) == 8'h01) inv = 8'(b);
      end
      s = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
      sbox_t[a] = s;
      isbox_t[s] = 8'(a);
    end
  endtask

  function automatic logic [127:0] ref_decrypt(input logic [127:0] key, input logic [127:0] ct);
    logic [31:0]  w[44];
    logic [7:0]   s[16];
    logic [7:0]   t[16];
    logic [7:0]   mc[4];
    logic [7:0]   rc;
    logic [31:0]  tmp;
    logic [127:0] res;
    mc[0] = 8'h0e; mc[1] = 8'h0b; mc[2] = 8'h0d; mc[3] = 8'h09;
    for (int i = 0; i < 4; i++) w[i] = key[127 - 32 * i -: 32];
    rc = 8'h01;
    for (int i = 4; i < 44; i++) begin
      tmp = w[i - 1];
      if (i % 4 == 0) begin
        tmp = {tmp[23:0], tmp[31:24]};
        tmp = {sbox_t[tmp[31:24]], sbox_t[tmp[23:16]], sbox_t[tmp[15:8]], sbox_t[tmp[7:0]]}
              ^ {rc, 24'h0};
        rc = gmul(rc, 8'h02);
      end
      w[i] = w[i - 4] ^ tmp;
    end
    for (int k = 0; k < 16; k++) s[k] = ct[127 - 8 * k -: 8];
    for (int r = 10; r >= 0; r--) begin
      if (r < 10) begin
        for (int c = 0; c < 4; c++)
          for (int j = 0; j < 4; j++) t[4 * c + j] = isbox_t[s[4 * ((c - j + 4) % 4) + j]];
        s = t;
      end
      for (int k = 0; k < 16; k++) s[k] = s[k] ^ w[4 * r + k / 4][31 - 8 * (k % 4) -: 8];
      if (r < 10 && r > 0) begin
        for (int c = 0; c < 4; c++) begin
          for (int j = 0; j < 4; j++) begin
            t[4 * c + j] = 8'h00;
            for (int m = 0; m < 4; m++)
              t[4 * c + j] = t[4 * c + j] ^ gmul(mc[(m - j + 4) % 4], s[4 * c + m]);
          end
        end
        s = t;
      end
    end
    for (int k = 0; k < 16; k++) res[127 - 8 * k -: 8] = s[k];
    return res;
  endfunction

  // Called #1 after an edge; returns #1 after the completion edge (valid_out high) or the abort.
  task automatic run_block(input logic [127:0] key, input logic [127:0] ct,
                           input int poke_at, input int abort_at);
    int           exp_lat, cnt;
    logic [127:0] exp_pt;
    logic         done, busy_ok, abort_now;
    exp_pt  = ref_decrypt(key, ct);
    exp_lat = 20;
`ifdef AES_DEC_KEY_CACHE_EN
    if (cache_vld && cache_key == key) exp_lat = 10;
    cache_vld = 1'b1;
    cache_key = key;
`endif
    key_drv  = key;
    ct_drv   = ct;
    start_in = 1'b1;
    @(posedge CLK);
    #1;
    start_in = 1'b0;
    key_drv  = {$urandom, $urandom, $urandom, $urandom};
    ct_drv   = {$urandom, $urandom, $urandom, $urandom};
    check_eq("busy_after_start", 128'(busy_out), 128'(1));
    cnt     = 0;
    done    = 1'b0;
    busy_ok = 1'b1;
    while (!done && cnt < 40) begin
      if (cnt == poke_at) start_in = 1'b1;
      if (cnt == poke_at + 1) start_in = 1'b0;
      abort_now = (cnt == abort_at);
      if (abort_now) RST = 1'b1;
      @(posedge CLK);
      #1;
      cnt++;
      if (abort_now) begin
        check_eq("abort_pt", pt_out, 128'h0);
        check_eq("abort_valid", 128'(valid_out), 128'(0));
        check_eq("abort_busy", 128'(busy_out), 128'(0));
        RST       = 1'b0;
        last_pt   = '0;
        cache_vld = 1'b0;
        return;
      end
      if (valid_out) begin
        done = 1'b1;
      end else begin
        if (!busy_out) busy_ok = 1'b0;
        if (cnt == 3) check_eq("pt_hold_busy", pt_out, last_pt);
      end
    end
    check_eq("valid_seen", 128'(done), 128'(1));
    check_eq("busy_during", 128'(busy_ok), 128'(1));
    check_eq("latency", 128'(cnt), 128'(exp_lat));
    check_eq("plaintext", pt_out, exp_pt);
    check_eq("busy_at_valid", 128'(busy_out), 128'(0));
    last_pt = exp_pt;
  endtask

  task automatic idle_check();
    @(posedge CLK);
    #1;
    check_eq("valid_one_cycle", 128'(valid_out), 128'(0));
    check_eq("busy_idle", 128'(busy_out), 128'(0));
    check_eq("pt_hold_idle", pt_out, last_pt);
  endtask

  localparam logic [127:0] K1 = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] C1 = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] P1 = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] K2 = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] C2 = 128'h3925841d02dc09fbdc118597196a0b32;
  localparam logic [127:0] P2 = 128'h3243f6a8885a308d313198a2e0370734;
  localparam logic [127:0] K3 = 128'h5468617473206d79204b756e67204675;
  localparam logic [127:0] C3 = 128'h29c3505f571420f6402299b31a02d73a;
  localparam logic [127:0] P3 = 128'h54776f204f6e65204e696e652054776f;

  initial begin
    logic [127:0] rkey, rct;
    RST       = 1'b1;
    start_in  = 1'b0;
    ct_drv    = '0;
    key_drv   = '0;
    cache_vld = 1'b0;
    cache_key = '0;
    last_pt   = '0;
    init_tables();

    repeat (2) @(posedge CLK);
    #1;
    // start held during reset must not launch a block
    start_in = 1'b1;
    key_drv  = K1;
    ct_drv   = C1;
    repeat (2) @(posedge CLK);
    #1;
    check_eq("reset_busy", 128'(busy_out), 128'(0));
    check_eq("reset_valid", 128'(valid_out), 128'(0));
    check_eq("reset_pt", pt_out, 128'h0);
    start_in = 1'b0;
    RST      = 1'b0;

    run_block(K1, C1, -1, -1);
    check_eq("vec1_pt", pt_out, P1);
    idle_check();
    run_block(K2, C2, -1, -1);
    check_eq("vec2_pt", pt_out, P2);
    idle_check();
    run_block(K3, C3, -1, -1);
    check_eq("vec3_pt", pt_out, P3);
    idle_check();

    // back-to-back with the same key, second start in the valid cycle
    run_block(K1, C1, -1, -1);
    run_block(K1, C1, -1, -1);
    check_eq("b2b_pt", pt_out, P1);
    idle_check();

    // start pulsed mid-block with other data is ignored
    run_block(K3, C3, 5, -1);
    check_eq("poke_pt", pt_out, P3);
    idle_check();

    // reset mid-block aborts, then a fresh block runs with full latency
    run_block(K1, C1, -1, 12);
    idle_check();
    run_block(K1, C1, -1, -1);
    check_eq("after_abort_pt", pt_out, P1);
    idle_check();

    rkey = '0;
    for (int i = 0; i < 8; i++) begin
      if (i == 0 || $urandom_range(0, 1) == 0) rkey = {$urandom, $urandom, $urandom, $urandom};
      rct = {$urandom, $urandom, $urandom, $urandom};
      run_block(rkey, rct, -1, -1);
      if ($urandom_range(0, 2) == 0) idle_check();
    end
    idle_check();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
